// File: rtl/serdes_8b10b_pkg.sv
// Shared definitions for the 8b10b transmit framer.
//   - K-character codes driven on tx_data with tx_k=1
//   - framer state encoding (ST_CRC exists only with SERDES_TX_FRAMER_CRC_EN)
//   - CRC-8 polynomial (0x07, MSB-first, no reflection) and byte update
// Optional feature macro: SERDES_TX_FRAMER_CRC_EN
package serdes_8b10b_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
  localparam logic [7:0] K27_7 = 8'hFB;  // start of packet
  localparam logic [7:0] K29_7 = 8'hFD;  // end of packet
  localparam logic [7:0] K28_0 = 8'h1C;  // underrun filler
  localparam logic [7:0] K30_7 = 8'hFE;  // abort

  localparam logic [7:0] CRC8_POLY = 8'h07;

`ifdef SERDES_TX_FRAMER_CRC_EN
  typedef enum logic [2:0] {ST_TRAIN, ST_IDLE, ST_DATA, ST_CRC, ST_EOP} state_t;
`else
  typedef enum logic [2:0] {ST_TRAIN, ST_IDLE, ST_DATA, ST_EOP} state_t;
`endif

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++)
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/serdes_8b10b_crc8.sv
// Byte-wide CRC-8 accumulator (poly 0x07, init 0x00).
// Ports:
//   clk_byte  byte clock
//   rst_in    synchronous reset, active-high
//   clr       clear accumulator to 0x00 (start of packet)
//   en        fold data into the accumulator
//   data      payload byte
//   crc       current CRC value
// Used only when SERDES_TX_FRAMER_CRC_EN is defined.
module serdes_8b10b_crc8
  import serdes_8b10b_pkg::*;
(
  input  logic       clk_byte,
  input  logic       rst_in,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clk_byte) begin
    if (rst_in || clr) crc <= 8'h00;
    else if (en)       crc <= crc8_next(crc, data);
  end

endmodule

// File: rtl/serdes_8b10b_tx_framer.sv
// Packet framer feeding the 8b10b SerDes transmit interface.
// Frames a valid/ready/last byte stream as K27.7, payload, K29.7 with K28.5
// idles between frames and during link training. Inserts K28.0 on source
// underrun, K30.7 on link loss mid-packet (then drops the rest of the packet).
// Ports:
//   clk_byte, rst_in                  byte clock, sync active-high reset
//   s_data/s_valid/s_last/s_ready     packet source
//   link_ready                        RX link up from SerDes core
//   tx_ready                          core accepts current character
//   tx_data/tx_k/tx_valid             character to core (registered)
//   pkt_count                         completed packets, wraps
//   underrun_count                    fillers inserted, saturates
//   abort_count                       aborted packets, saturates
// Optional feature macro: SERDES_TX_FRAMER_CRC_EN (CRC-8 byte before K29.7)
module serdes_8b10b_tx_framer
  import serdes_8b10b_pkg::*;
#(
  parameter int TRAIN_LEN = 64,
  parameter int MIN_IFG   = 2
) (
  input  logic        clk_byte,
  input  logic        rst_in,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        link_ready,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_k,
  output logic        tx_valid,
  output logic [15:0] pkt_count,
  output logic [15:0] underrun_count,
  output logic [7:0]  abort_count
);

  localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam int IW = $clog2(MIN_IFG + 1);

  state_t          state;
  logic            drop_mode;
  logic [TW-1:0]   train_cnt;
  logic [IW-1:0]   ifg_cnt;
  logic            adv;
  logic            sop_go;
  logic            cur_comma;

  // Everything advances only when the current character is taken by the core.
  assign adv       = tx_ready && tx_valid;
  assign s_ready   = tx_ready && (state == ST_DATA || drop_mode);
  assign cur_comma = tx_k && (tx_data == K28_5);
  assign sop_go    = (state == ST_IDLE) && link_ready && s_valid && !drop_mode &&
                     (ifg_cnt == IW'(MIN_IFG));

`ifdef SERDES_TX_FRAMER_CRC_EN
  logic [7:0] crc;
  logic       crc_clr;
  logic       crc_en;

  assign crc_clr = adv && sop_go;
  assign crc_en  = adv && (state == ST_DATA) && link_ready && s_valid;

  serdes_8b10b_crc8 u_crc (
    .clk_byte (clk_byte),
    .rst_in   (rst_in),
    .clr      (crc_clr),
    .en       (crc_en),
    .data     (s_data),
    .crc      (crc)
  );
`endif

  always_ff @(posedge clk_byte) begin
    if (rst_in) begin
      state          <= ST_TRAIN;
      drop_mode      <= 1'b0;
      train_cnt      <= '0;
      ifg_cnt        <= '0;
      tx_data        <= K28_5;
      tx_k           <= 1'b1;
      tx_valid       <= 1'b0;
      pkt_count      <= '0;
      underrun_count <= '0;
      abort_count    <= '0;
    end else begin
      tx_valid <= 1'b1;
      // Discarded beats of an aborted packet; the last one ends drop mode.
      if (drop_mode && s_valid && s_ready && s_last) drop_mode <= 1'b0;
      if (adv) begin
        case (state)
          ST_TRAIN: begin
            tx_data <= K28_5;
            tx_k    <= 1'b1;
            if (!link_ready) begin
              train_cnt <= '0;
            end else if (cur_comma) begin
              // Only commas actually taken by the core count as training;
              // the K30.7 that led here does not.
              if (train_cnt == TW'(TRAIN_LEN - 1)) begin
                state     <= ST_IDLE;
                train_cnt <= '0;
                ifg_cnt   <= IW'(1);  // comma loaded now is the first IFG idle
              end else begin
                train_cnt <= train_cnt + 1'b1;
              end
            end
          end
          ST_IDLE: begin
            tx_k <= 1'b1;
            if (!link_ready) begin
              state     <= ST_TRAIN;
              train_cnt <= '0;
              tx_data   <= K28_5;
            end else if (sop_go) begin
              state   <= ST_DATA;
              tx_data <= K27_7;
            end else begin
              tx_data <= K28_5;
              if (ifg_cnt != IW'(MIN_IFG)) ifg_cnt <= ifg_cnt + 1'b1;
            end
          end
          default: begin  // ST_DATA, ST_CRC, ST_EOP
            if (!link_ready) begin
              state     <= ST_TRAIN;
              train_cnt <= '0;
              tx_data   <= K30_7;
              tx_k      <= 1'b1;
              if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
              // A beat taken this cycle is discarded; if it was the last one
              // there is nothing left to drop.
              if (state == ST_DATA && !(s_valid && s_last)) drop_mode <= 1'b1;
            end else if (state == ST_DATA) begin
              if (s_valid) begin
                tx_data <= s_data;
                tx_k    <= 1'b0;
`ifdef SERDES_TX_FRAMER_CRC_EN
                if (s_last) state <= ST_CRC;
`else
                if (s_last) state <= ST_EOP;
`endif
              end else begin
                tx_data <= K28_0;
                tx_k    <= 1'b1;
                if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
              end
`ifdef SERDES_TX_FRAMER_CRC_EN
            end else if (state == ST_CRC) begin
              tx_data <= crc;
              tx_k    <= 1'b0;
              state   <= ST_EOP;
`endif
            end else begin
              tx_data   <= K29_7;
              tx_k      <= 1'b1;
              pkt_count <= pkt_count + 16'd1;
              ifg_cnt   <= '0;
              state     <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
